// File: rtl/pending_event_encoder_pkg.sv
// Shared constants, FSM state type and the priority-select helper
// for the pending event encoder.
package pending_event_encoder_pkg;

    localparam int NUM_LINES = 8;
    localparam int CODE_W    = 3;

    typedef enum logic {
        IDLE    = 1'b0,
        PRESENT = 1'b1
    } state_e;

    // Return the first set bit of vec found by scanning upward from start,
    // wrapping around. The index arithmetic wraps naturally in CODE_W bits.
    function automatic logic [CODE_W-1:0] sel_from(
        input logic [NUM_LINES-1:0] vec,
        input logic [CODE_W-1:0]    start
    );
        logic [CODE_W-1:0] res;
        logic [CODE_W-1:0] idx;
        logic              found;
        res   = '0;
        idx   = '0;
        found = 1'b0;
        for (int i = 0; i < NUM_LINES; i++) begin
            idx = start + CODE_W'(i);
            if (!found && vec[idx]) begin
                res   = idx;
                found = 1'b1;
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/sync_edge_detect.sv
// Input synchronizer (SYNC_STAGES deep, 0 = bypass), previous-value
// register and per-line rising-edge detection for all request lines.
module sync_edge_detect
    import pending_event_encoder_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NUM_LINES-1:0] req_i,
    output logic [NUM_LINES-1:0] rise_o
);

    logic [NUM_LINES-1:0] sync;
    logic [NUM_LINES-1:0] prev_q;
    logic [NUM_LINES-1:0] prev_d;

    generate
        if (SYNC_STAGES == 0) begin : g_bypass
            assign sync = req_i;
        end else begin : g_sync
            logic [SYNC_STAGES-1:0][NUM_LINES-1:0] sync_q;
            logic [SYNC_STAGES-1:0][NUM_LINES-1:0] sync_d;

            // Shift the raw request lines through the synchronizer chain.
            always_comb begin
                sync_d[0] = req_i;
                for (int s = 1; s < SYNC_STAGES; s++) begin
                    sync_d[s] = sync_q[s-1];
                end
            end

            // Synchronizer flops.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) sync_q <= '0;
                else        sync_q <= sync_d;
            end

            assign sync = sync_q[SYNC_STAGES-1];
        end
    endgenerate

    // prev clears on reset, so a line held high across reset release
    // yields exactly one rise.
    always_comb begin
        prev_d = sync;
    end

    // Previous-value register for edge detection.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) prev_q <= '0;
        else        prev_q <= prev_d;
    end

    assign rise_o = sync & ~prev_q;

endmodule

// File: rtl/pending_event_encoder.sv
// Pending event encoder: latches rising edges of 8 asynchronous request
// lines into a pending register and presents one index at a time over a
// valid/ready handshake. Optional macro ROUND_ROBIN_EN switches the
// selector from fixed lowest-index priority to round-robin.
module pending_event_encoder
    import pending_event_encoder_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NUM_LINES-1:0] req_i,
    output logic [CODE_W-1:0]    code_o,
    output logic                 valid_o,
    input  logic                 ready_i,
    output logic [NUM_LINES-1:0] pending_o,
    output logic                 overflow_o,
    input  logic                 clr_ovf_i
);

    logic [NUM_LINES-1:0] rise;
    logic [NUM_LINES-1:0] clr;
    logic                 accept;
    logic [NUM_LINES-1:0] pending_q, pending_d;
    logic                 ovf_q, ovf_d;
    state_e               state_q, state_d;
    logic [CODE_W-1:0]    code_q, code_d;
    logic [CODE_W-1:0]    sel_start;

    sync_edge_detect #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync (
        .clk    (clk),
        .rst_n  (rst_n),
        .req_i  (req_i),
        .rise_o (rise)
    );

    // Handshake accept and the one-hot clear of the presented line.
    always_comb begin
        accept = (state_q == PRESENT) && ready_i;
        clr    = '0;
        if (accept) clr[code_q] = 1'b1;
    end

    // Pending update; a rise on the line being cleared wins and is not
    // counted as lost. A new loss outranks a same-cycle clear request.
    always_comb begin
        pending_d = (pending_q & ~clr) | rise;
        ovf_d     = (ovf_q & ~clr_ovf_i) | (|(rise & pending_q & ~clr));
    end

`ifdef ROUND_ROBIN_EN
    logic [CODE_W-1:0] ptr_q, ptr_d;

    // Search starts just past the last granted line; pointer moves on accept.
    always_comb begin
        sel_start = ptr_q + CODE_W'(1);
        ptr_d     = accept ? code_q : ptr_q;
    end

    // Round-robin pointer register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) ptr_q <= CODE_W'(NUM_LINES - 1);
        else        ptr_q <= ptr_d;
    end
`else
    // Fixed priority: always search from line 0.
    always_comb begin
        sel_start = '0;
    end
`endif

    // Presentation FSM next-state: code is loaded only on entry to PRESENT.
    always_comb begin
        state_d = state_q;
        code_d  = code_q;
        case (state_q)
            IDLE: begin
                if (pending_q != '0) begin
                    code_d  = sel_from(pending_q, sel_start);
                    state_d = PRESENT;
                end
            end
            PRESENT: begin
                if (ready_i) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State, code, pending and overflow registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            code_q    <= '0;
            pending_q <= '0;
            ovf_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            code_q    <= code_d;
            pending_q <= pending_d;
            ovf_q     <= ovf_d;
        end
    end

    assign code_o     = code_q;
    assign valid_o    = (state_q == PRESENT);
    assign pending_o  = pending_q;
    assign overflow_o = ovf_q;

endmodule

// File: tb/tb_pending_event_encoder.sv
// Self-checking bench for pending_event_encoder: directed scenarios with
// constant expectations plus randomized traffic against a reference model.
module tb_pending_event_encoder;

    localparam int SS = 2;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] req_i;
    logic [2:0] code_o;
    logic       valid_o;
    logic       ready_i;
    logic [7:0] pending_o;
    logic       overflow_o;
    logic       clr_ovf_i;

    int checks   = 0;
    int failures = 0;

    pending_event_encoder #(.SYNC_STAGES(SS)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_i      (req_i),
        .code_o     (code_o),
        .valid_o    (valid_o),
        .ready_i    (ready_i),
        .pending_o  (pending_o),
        .overflow_o (overflow_o),
        .clr_ovf_i  (clr_ovf_i)
    );

    always #5 clk = ~clk;

    // Reference model: req history, last synchronized value, pending set,
    // presented code and sticky loss flag.
    logic [7:0] m_hist [0:3];
    logic [7:0] m_prev;
    logic [7:0] m_pend;
    bit         m_pres;
    int         m_code;
    bit         m_ovf;
    int         m_ptr;

    task automatic model_reset();
        for (int k = 0; k < 4; k++) m_hist[k] = 8'h00;
        m_prev = 8'h00;
        m_pend = 8'h00;
        m_pres = 0;
        m_code = 0;
        m_ovf  = 0;
        m_ptr  = 7;
    endtask

    function automatic int m_sel(input logic [7:0] v, input int ptr);
        int start;
`ifdef ROUND_ROBIN_EN
        start = (ptr + 1) % 8;
`else
        start = 0;
`endif
        for (int k = 0; k < 8; k++) begin
            if (v[(start + k) % 8]) return (start + k) % 8;
        end
        return 0;
    endfunction

    // Advance one clock edge and the model alongside it; outputs are then
    // stable and inputs may be changed (1 time unit after the edge).
    task automatic tick();
        logic [7:0] sync_now, rise, clr, n_pend;
        bit         n_pres, n_ovf;
        int         n_code, n_ptr;
        if (!rst_n) begin
            @(posedge clk);
            #1;
            model_reset();
            return;
        end
        sync_now = (SS == 0) ? req_i : m_hist[SS];
        rise     = sync_now & ~m_prev;
        clr      = (m_pres && ready_i) ? (8'h01 << m_code) : 8'h00;
        n_pend   = (m_pend & ~clr) | rise;
        n_ovf    = ((rise & m_pend & ~clr) != 0) || (m_ovf && !clr_ovf_i);
        n_pres   = m_pres;
        n_code   = m_code;
        n_ptr    = (m_pres && ready_i) ? m_code : m_ptr;
        if (!m_pres && m_pend != 0) begin
            n_pres = 1;
            n_code = m_sel(m_pend, m_ptr);
        end else if (m_pres && ready_i) begin
            n_pres = 0;
        end
        @(posedge clk);
        #1;
        for (int k = 3; k >= 2; k--) m_hist[k] = m_hist[k-1];
        m_hist[1] = req_i;
        m_prev = sync_now;
        m_pend = n_pend;
        m_ovf  = n_ovf;
        m_pres = n_pres;
        m_code = n_code;
        m_ptr  = n_ptr;
    endtask

    task automatic wait_valid(output bit ok);
        ok = 0;
        for (int i = 0; i < 20; i++) begin
            if (valid_o === 1'b1) begin
                ok = 1;
                return;
            end
            tick();
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; req_i = 8'h08; ready_i = 1'b0; clr_ovf_i = 1'b0;
        model_reset();
        #3;
        checks++;
        if (valid_o !== 1'b0 || pending_o !== 8'h00 || overflow_o !== 1'b0 || code_o !== 3'd0) begin
            failures++;
            $display("FAIL reset_state: valid=%b pending=%h ovf=%b code=%0d, need 0/00/0/0",
                     valid_o, pending_o, overflow_o, code_o);
        end
        tick(); tick();
        rst_n = 1'b1;
        // Line 3 held high across release: exactly one event.
        for (int k = 1; k <= SS + 2; k++) tick();
        checks++;
        if (valid_o !== 1'b1 || code_o !== 3'd3) begin
            failures++;
            $display("FAIL reset_held_line: valid=%b code=%0d, need 1/3", valid_o, code_o);
        end
        ready_i = 1'b1;
        tick();
        begin
            bit again;
            again = 0;
            for (int k = 0; k < 8; k++) begin
                tick();
                if (valid_o !== 1'b0 || pending_o !== 8'h00) again = 1;
            end
            checks++;
            if (again) begin
                failures++;
                $display("FAIL reset_single_event: extra event seen, valid=%b pending=%h, need 0/00",
                         valid_o, pending_o);
            end
        end
        req_i = 8'h00;
        repeat (SS + 2) tick();
    endtask

    task automatic test_burst();
        int got[$];
        int when[$];
        int exp[3];
`ifdef ROUND_ROBIN_EN
        exp = '{5, 7, 2};   // pointer left at 3 by the previous grant
`else
        exp = '{2, 5, 7};
`endif
        req_i = 8'hA4; ready_i = 1'b1;
        for (int k = 1; k <= 14; k++) begin
            tick();
            if (valid_o === 1'b1) begin
                got.push_back(int'(code_o));
                when.push_back(k);
            end
        end
        checks++;
        if (got.size() != 3 || got[0] != exp[0] || got[1] != exp[1] || got[2] != exp[2]) begin
            failures++;
            $display("FAIL burst_order: got %p, need %p", got, exp);
        end
        checks++;
        if (when.size() != 3 || when[0] != SS + 2 || when[1] != when[0] + 2 || when[2] != when[1] + 2) begin
            failures++;
            $display("FAIL burst_spacing: valid on ticks %p, need %0d,%0d,%0d", when, SS+2, SS+4, SS+6);
        end
        req_i = 8'h00;
        repeat (SS + 2) tick();
    endtask

    task automatic test_latency();
        bit bad;
        bad = 0;
        req_i = 8'h08; ready_i = 1'b1;
        for (int k = 1; k <= SS + 2; k++) begin
            tick();
            if (valid_o !== ((k == SS + 2) ? 1'b1 : 1'b0)) bad = 1;
        end
        checks++;
        if (bad || code_o !== 3'd3) begin
            failures++;
            $display("FAIL latency: valid=%b code=%0d after %0d edges, need 1/3 only at last edge",
                     valid_o, code_o, SS + 2);
        end
        tick();
        checks++;
        if (valid_o !== 1'b0 || pending_o !== 8'h00) begin
            failures++;
            $display("FAIL latency_accept: valid=%b pending=%h, need 0/00", valid_o, pending_o);
        end
        req_i = 8'h00;
        repeat (SS + 2) tick();
    endtask

    task automatic test_overflow();
        bit ok;
        ready_i = 1'b0;
        req_i = 8'h02; tick(); req_i = 8'h00;
        wait_valid(ok);
        checks++;
        if (!ok || code_o !== 3'd1) begin
            failures++;
            $display("FAIL ovf_present: ok=%0d code=%0d, need 1/1", ok, code_o);
        end
        req_i = 8'h02; tick(); req_i = 8'h00;
        repeat (SS + 2) tick();
        checks++;
        if (overflow_o !== 1'b1 || valid_o !== 1'b1 || code_o !== 3'd1) begin
            failures++;
            $display("FAIL ovf_set: ovf=%b valid=%b code=%0d, need 1/1/1", overflow_o, valid_o, code_o);
        end
        clr_ovf_i = 1'b1; tick(); clr_ovf_i = 1'b0;
        checks++;
        if (overflow_o !== 1'b0) begin
            failures++;
            $display("FAIL ovf_clear: ovf=%b, need 0", overflow_o);
        end
        // Clear request landing on the same edge as a new loss.
        req_i = 8'h02;
        repeat (SS) tick();
        clr_ovf_i = 1'b1; tick(); clr_ovf_i = 1'b0; req_i = 8'h00;
        checks++;
        if (overflow_o !== 1'b1) begin
            failures++;
            $display("FAIL ovf_clear_collision: ovf=%b, need 1", overflow_o);
        end
        repeat (SS + 1) tick();
        clr_ovf_i = 1'b1; tick(); clr_ovf_i = 1'b0;
        ready_i = 1'b1; tick();
        checks++;
        if (valid_o !== 1'b0 || pending_o !== 8'h00 || overflow_o !== 1'b0) begin
            failures++;
            $display("FAIL ovf_drain: valid=%b pending=%h ovf=%b, need 0/00/0", valid_o, pending_o, overflow_o);
        end
        repeat (SS + 2) tick();
    endtask

    task automatic test_clear_collision();
        bit ok;
        ready_i = 1'b0;
        req_i = 8'h10; tick(); req_i = 8'h00;
        wait_valid(ok);
        repeat (SS + 1) tick();
        checks++;
        if (!ok || code_o !== 3'd4) begin
            failures++;
            $display("FAIL coll_present: ok=%0d code=%0d, need 1/4", ok, code_o);
        end
        req_i = 8'h10;
        repeat (SS) tick();
        ready_i = 1'b1; tick();
        checks++;
        if (pending_o[4] !== 1'b1 || overflow_o !== 1'b0 || valid_o !== 1'b0) begin
            failures++;
            $display("FAIL coll_keep: pending=%h ovf=%b valid=%b, need bit4=1/0/0", pending_o, overflow_o, valid_o);
        end
        tick();
        checks++;
        if (valid_o !== 1'b1 || code_o !== 3'd4) begin
            failures++;
            $display("FAIL coll_represent: valid=%b code=%0d, need 1/4", valid_o, code_o);
        end
        tick();
        req_i = 8'h00;
        repeat (SS + 2) tick();
    endtask

    task automatic test_round_robin();
        bit ok;
        int got[$];
        ready_i = 1'b1;
        req_i = 8'h40;
        wait_valid(ok);
        checks++;
        if (!ok || code_o !== 3'd6) begin
            failures++;
            $display("FAIL rr_grant6: ok=%0d code=%0d, need 1/6", ok, code_o);
        end
        tick();
        req_i = 8'h00;
        repeat (SS + 2) tick();
        req_i = 8'h41;
        for (int k = 0; k < 10; k++) begin
            tick();
            if (valid_o === 1'b1) got.push_back(int'(code_o));
        end
        checks++;
        if (got.size() != 2 || got[0] != 0 || got[1] != 6) begin
            failures++;
            $display("FAIL rr_order: got %p, need 0 then 6", got);
        end
        req_i = 8'h00;
        repeat (SS + 2) tick();
    endtask

    task automatic test_async_reset();
        bit ok;
        ready_i = 1'b0;
        req_i = 8'h01; tick(); req_i = 8'h00;
        wait_valid(ok);
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (!ok || valid_o !== 1'b0 || pending_o !== 8'h00) begin
            failures++;
            $display("FAIL async_reset: ok=%0d valid=%b pending=%h, need 1/0/00", ok, valid_o, pending_o);
        end
        model_reset();
        tick();
        rst_n = 1'b1;
        repeat (SS + 2) tick();
    endtask

    task automatic test_random();
        int bad = 0;
        int ovf_seen = 0;
        int codes_seen = 0;
        rst_n = 1'b0; req_i = 8'h00; ready_i = 1'b0; clr_ovf_i = 1'b0;
        tick();
        rst_n = 1'b1;
        for (int c = 0; c < 600; c++) begin
            req_i     = req_i ^ (8'($urandom) & 8'($urandom) & 8'($urandom));
            ready_i   = ($urandom_range(0, 3) != 0);
            clr_ovf_i = ($urandom_range(0, 15) == 0);
            if (c == 300) rst_n = 1'b0;
            tick();
            rst_n = 1'b1;
            if (valid_o === 1'b1) codes_seen++;
            if (overflow_o === 1'b1) ovf_seen++;
            checks++;
            if (valid_o !== m_pres || (m_pres && code_o !== 3'(m_code)) || code_o !== 3'(m_code) ||
                pending_o !== m_pend || overflow_o !== m_ovf) begin
                failures++;
                bad++;
                if (bad <= 5)
                    $display("FAIL random[%0d]: valid=%b code=%0d pend=%h ovf=%b, need %0d/%0d/%h/%0d",
                             c, valid_o, code_o, pending_o, overflow_o, m_pres, m_code, m_pend, m_ovf);
            end
        end
        checks++;
        if (codes_seen == 0) begin
            failures++;
            $display("FAIL random_activity: codes presented=%0d, need >0", codes_seen);
        end
        req_i = 8'h00; ready_i = 1'b1; clr_ovf_i = 1'b0;
        repeat (SS + 12) tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_burst();
        test_latency();
        test_overflow();
        test_clear_collision();
        test_round_robin();
        test_async_reset();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
